// File: rtl/ex_muldiv_iter.sv
// Iterative multiply / multiply-accumulate / divide unit for the EX stage.
// Start/busy/done handshake; flush cancels an operation in flight.
module ex_muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   hilo_in,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int K  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(K - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  if (WIDTH % MUL_STEP != 0) begin : g_bad_step
    $error("ex_muldiv_iter: MUL_STEP must divide WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t               r_state, w_next;
  logic                 r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_a_raw;
  logic [2*WIDTH-1:0]   r_hilo;
  // Multiply: r_mcand is the shifting multiplicand, r_mplier the multiplier.
  // Divide: r_mcand[WIDTH-1:0] holds the divisor, r_mplier dividend -> quotient.
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       r_rem;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg_pq, r_neg_r, r_div0;
  logic [WIDTH-1:0]     r_hi, r_lo;

  logic                 w_launch, w_signed, w_is_div, w_b_zero, w_r_is_div;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0]   w_pp, w_prod, w_fix_hilo;
  logic [WIDTH:0]       w_shift, w_diff;

  assign w_launch   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
  assign w_signed   = ~op[0];
  assign w_is_div   = (op[2:1] == 2'b01);
  assign w_b_zero   = (b == '0);
  assign w_abs_a    = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b    = (w_signed && b[WIDTH-1]) ? -b : b;
  assign w_r_is_div = (r_op[2:1] == 2'b01);

  assign w_shift = {r_rem[WIDTH-1:0], r_mplier[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_mcand[WIDTH-1:0]};
  assign w_prod  = r_neg_pq ? -r_acc : r_acc;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
    end
  end

  always_comb begin
    w_fix_hilo = w_prod;
    if (w_r_is_div) begin
      if (r_div0) w_fix_hilo = {r_a_raw, {WIDTH{1'b1}}};
      else        w_fix_hilo = {(r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]),
                                (r_neg_pq ? -r_mplier : r_mplier)};
    end else if (r_op[2]) begin
      w_fix_hilo = r_op[1] ? (r_hilo - w_prod) : (r_hilo + w_prod);
    end
  end

  // State register; busy/done are registered alongside it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_launch ? (w_is_div ? (w_b_zero ? S_FIX : S_DIV) : S_MUL)
                                        : S_IDLE;
      S_MUL, S_DIV:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_comb begin
    w_busy_nxt = (w_next == S_MUL) || (w_next == S_DIV) || (w_next == S_FIX);
    w_done_nxt = (w_next == S_DONE);
  end

  // NOTE: the reset is synchronous and clears every datapath register, not just the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a_raw  <= '0;
      r_hilo   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_pq <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_launch) begin
        r_op     <= op;
        r_a_raw  <= a;
        r_hilo   <= hilo_in;
        r_mcand  <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_b : w_abs_a)};
        r_mplier <= w_is_div ? w_abs_a : w_abs_b;
        r_acc    <= '0;
        r_rem    <= '0;
        r_cnt    <= w_is_div ? DIV_LAST : MUL_LAST;
        r_neg_pq <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r  <= w_signed & a[WIDTH-1];
        r_div0   <= w_b_zero;
      end else if (r_state == S_MUL) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << MUL_STEP;
        r_mplier <= r_mplier >> MUL_STEP;
        r_cnt    <= r_cnt - CW'(1);
      end else if (r_state == S_DIV) begin
        // Restoring step: keep the trial difference only when it did not go negative.
        r_rem    <= w_diff[WIDTH] ? w_shift : w_diff;
        r_mplier <= {r_mplier[WIDTH-2:0], ~w_diff[WIDTH]};
        r_cnt    <= r_cnt - CW'(1);
      end
      if ((r_state == S_FIX) && !flush) {r_hi, r_lo} <= w_fix_hilo;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/ex_muldiv_iter.md
# ex_muldiv_iter

Parametrised iterative multiply/divide unit for the execute stage. It covers signed and unsigned multiply, multiply-accumulate and multiply-subtract, and adds signed and unsigned division, which the current multi-cycle unit lacks. It takes operands and the forwarded HI/LO value from the EX stage under a start/busy/done handshake. The EX stage stalls on `busy` and writes `{hi, lo}` to HI/LO when `done` is set. A pipeline `flush` cancels an operation in flight.

## Interface
- `WIDTH`, default 32: operand width; HI/LO is 2*WIDTH bits.
- `MUL_STEP`, default 4: multiplier bits retired per cycle. `WIDTH % MUL_STEP` must be 0; elaboration fails otherwise.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `start` in, 1: launch request, sampled only in IDLE or DONE.
- `op` in, 3: operation select.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `a` in, WIDTH: rs operand, multiplicand or dividend.
- `b` in, WIDTH: rt operand, multiplier or divisor.
- `hilo_in` in, 2*WIDTH: forwarded `{HI, LO}`, used only by ops 4–7.
- `flush` in, 1: abort the current operation.
- `busy` out, 1: operation in progress; EX stalls while it is 1.
- `done` out, 1: one-cycle pulse; `hi`/`lo` are valid that cycle.
- `hi` out, WIDTH: product high half, or remainder.
- `lo` out, WIDTH: product low half, or quotient.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **Launch.** In IDLE or DONE, `start`=1 and `flush`=0 registers `a`, `b`, `op` and `hilo_in`. Inputs need not be held afterwards.
  - ops 0, 1, 4–7 go to MUL.
  - ops 2, 3 with `b`≠0 go to DIV.
  - ops 2, 3 with `b`=0 go straight to FIX.
- **Sign handling.** For signed ops (0, 2, 4, 6) the operands are replaced by their absolute values, and the result signs are recorded:
  - product sign = `a[W-1]` ^ `b[W-1]`;
  - quotient sign = `a[W-1]` ^ `b[W-1]`;
  - remainder sign = `a[W-1]`.
  - Absolute value of the most negative input is its own unsigned bit pattern, with no saturation.
- **MUL.** Shift-add, `MUL_STEP` multiplier bits per cycle into a 2*WIDTH-bit accumulator. Runs K = WIDTH/MUL_STEP cycles, then goes to FIX.
- **DIV.** Restoring division, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder. Runs K = WIDTH cycles, then goes to FIX.
- **FIX.** One cycle, then DONE.
  - Multiply: apply the sign by two's-complement negation over 2*WIDTH bits. Ops 4/5 then compute `hilo_in` + P; ops 6/7 compute `hilo_in` − P. Both are mod 2^(2*WIDTH), with no overflow flag.
  - Divide: negate the quotient and/or remainder according to the recorded signs.
  - Divide by zero: `lo` = all ones, `hi` = `a` as registered, with no sign fix.
  - The results load into the `hi`/`lo` registers.
- **DONE.** `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
  - A `start` sampled in DONE launches a new operation, so back-to-back operations are allowed.
  - `hi`/`lo` hold their value until the next FIX.
- **Flush.** `flush`=1 in any state returns to IDLE on the next edge.
  - `busy` and `done` are 0 from the next cycle.
  - `hi`/`lo` are unchanged.
  - `flush` has priority over a simultaneous `start`, which is dropped.
- **Start while busy.** A `start` in MUL, DIV or FIX is ignored; the current operation continues unaffected.
- **Reset.** `rst` in any state, including mid-operation, returns to IDLE. Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, and internal operand and accumulator registers 0.

## Timing
- Convention: `start` is sampled at the end of cycle T.
- Multiply (ops 0, 1, 4–7): `busy`=1 in cycles T+1 … T+K+1, `done` in cycle T+K+2.
  - Default parameters (K=8): `done` at T+10.
- Divide, `b`≠0: `busy`=1 in cycles T+1 … T+WIDTH+1, `done` in cycle T+WIDTH+2.
  - WIDTH=32: `done` at T+34.
- Divide by zero: FIX in T+1, `done` at T+2.
- All outputs are registered; there is no combinational path from inputs to `busy`, `done`, `hi` or `lo`.
- `busy` rises in cycle T+1, not T. The EX stage covers cycle T by decoding `op` itself.

## Test plan
- **Signed multiply.** MULT `a`=0xFFFFFFFE, `b`=3 → at T+10, `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; `busy`=1 in T+1..T+9 only.
- **Multiply-accumulate and multiply-subtract.**
  - MADDU `hilo_in`=0x00000001_FFFFFFFF, `a`=1, `b`=1 → `{hi,lo}`=0x00000002_00000000.
  - MSUB `hilo_in`=0, `a`=2, `b`=3 → 0xFFFFFFFF_FFFFFFFA.
- **Division.**
  - DIV `a`=0xFFFFFFF9 (−7), `b`=2 → at T+34, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 100/7 → `lo`=14, `hi`=2.
- **Divide by zero.** DIVU `a`=7, `b`=0 → `done` at T+2, `lo`=0xFFFFFFFF, `hi`=7.
- **Flush and reset.**
  - MULT launched, `flush` at T+5 → `busy`=0 from T+6, no `done` within 40 cycles, `hi`/`lo` equal their prior values.
  - `rst` at T+3 of a DIV → all outputs 0 next cycle.
- **Handshake corners.**
  - `start` during `busy` with different operands → first result unchanged, no second `done`.
  - `start` in the DONE cycle → second `done` exactly K+2 cycles later.
  - `start`+`flush` in the same cycle → no launch.
